sbox_build_ctrl: RTL and testbench
==================================

Name: sbox_build_ctrl

Overview:
- Sequences S-box generation for the chaotic image cipher.
- Consumes a stream of candidate bytes from the chaotic-map generator and rejects duplicates with a 256-entry used bitmap.
- Drives the S-box memory's sequential write port (write enable + data) with exactly 256 unique values, forming a permutation of 0..255.
- If the chaotic source fails to cover all values within a candidate budget, fills the remaining entries deterministically in ascending order.

Parameters:
- MAX_CANDIDATES, 4096: candidate budget per build (accepted candidates, duplicates included) before FILL mode; legal range 256..65535.
- CNT_W, 16: width of the candidate counter; must hold MAX_CANDIDATES.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a build from IDLE or DONE; ignored while busy.
- cand_valid  input  1  candidate byte available.
- cand_data  input  8  candidate byte from chaotic generator.
- cand_ready  output  1  controller accepts a candidate this cycle; high only in COLLECT.
- sbox_we  output  1  S-box write enable, one pulse per unique value.
- sbox_wdata  output  8  value written to the S-box.
- busy  output  1  high in COLLECT or FILL.
- done  output  1  high in DONE until the next start or rst.
- filled  output  1  high once FILL mode has been entered; held until the next start or rst.
- write_count  output  9  unique values written this build, 0..256.
- cand_count  output  CNT_W  candidates accepted this build.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; bitmap cleared; all outputs 0. Reset wins over every other input. A reset mid-build abandons the build; the S-box must be reset by the same rst so its write index also returns to 0.
- States:
  - IDLE: start -> COLLECT.
  - COLLECT: build from the candidate stream.
  - FILL: deterministic fill of unused values.
  - DONE: start -> COLLECT.
- On start: in that same edge clear the bitmap, write_count, cand_count, filled and scan_ptr.
- COLLECT:
  - cand_ready=1. Accept = cand_valid & cand_ready.
  - On accept: cand_count+1.
  - If used[cand_data]=0: set used[cand_data], write_count+1, and register sbox_we=1 with sbox_wdata=cand_data for the next cycle (latency 1 from accept edge to write cycle).
  - Duplicate: no write; sbox_we=0 next cycle.
  - Back-to-back identical candidates: the second is a duplicate, because the bitmap updates on the accept edge.
- Transitions out of COLLECT (evaluated on the accept edge):
  - write_count reaches 256 -> DONE.
  - Else if cand_count reaches MAX_CANDIDATES -> FILL, filled=1.
  - If both occur on the same edge, DONE takes priority.
- FILL:
  - cand_ready=0. scan_ptr (8-bit) starts at 0 and increments by 1 every cycle.
  - If used[scan_ptr]=0: set the bit, write_count+1, sbox_we=1 and sbox_wdata=scan_ptr next cycle.
  - When write_count reaches 256 -> DONE. scan_ptr never needs to wrap, because all unused values are at or above the scan position.
- DONE: cand_ready=0, busy=0, done=1. The final sbox_we pulse occurs in the first DONE cycle. The bitmap holds all ones.
- sbox_we is never high for more than 256 cycles per build, so the downstream 8-bit write index wraps back to 0 at build end.
- cand_data is ignored when cand_valid=0. Gaps in cand_valid only stall the build; there is no timeout other than MAX_CANDIDATES.
- start asserted during COLLECT or FILL has no effect.

Test Plan:
- rst; start; stream cand_data 0x00..0xFF with cand_valid=1 every cycle -> 256 sbox_we pulses, each 1 cycle after its accept; sbox_wdata equals the stream; done=1; filled=0; cand_count=256.
- Stream 0x05,0x05,0x07,0x05 -> exactly two writes (0x05, 0x07); cand_count=4; write_count=2.
- MAX_CANDIDATES=300; stream a constant 0xAA -> one write of 0xAA; after 300 accepts FILL writes 0x00..0xA9, 0xAB..0xFF in ascending order; filled=1; done=1; write_count=256.
- Random stream with cand_valid toggling 50% -> writes only on accepted cycles; output is a permutation of 0..255 (checked by scoreboard); cand_ready=0 after DONE.
- rst asserted mid-COLLECT after 100 writes -> next cycle all outputs 0, state IDLE; a new start gives a fresh permutation with no duplicates from the aborted build.
- start pulsed during COLLECT -> ignored, counts continue; start in DONE -> counters and bitmap cleared, new build begins.

Source files
------------

// File: rtl/sbox_build_ctrl.sv
// sbox_build_ctrl: builds a 256-entry S-box permutation from a chaotic
// candidate byte stream, rejecting duplicates with a used-value bitmap and
// falling back to an ascending fill of unused values once the candidate
// budget is spent.
module sbox_build_ctrl #(
    parameter int unsigned MAX_CANDIDATES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cand_valid,
    input  logic [7:0]       cand_data,
    output logic             cand_ready,
    output logic             sbox_we,
    output logic [7:0]       sbox_wdata,
    output logic             busy,
    output logic             done,
    output logic             filled,
    output logic [8:0]       write_count,
    output logic [CNT_W-1:0] cand_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FILL    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [255:0]       used_q, used_d;
    logic [8:0]         write_count_q, write_count_d;
    logic [CNT_W-1:0]   cand_count_q, cand_count_d;
    logic [7:0]         scan_ptr_q, scan_ptr_d;
    logic               sbox_we_q, sbox_we_d;
    logic [7:0]         sbox_wdata_q, sbox_wdata_d;
    logic               filled_q, filled_d;

    // Next-state, bitmap update and registered write-port request.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d       = state_q;
        used_d        = used_q;
        write_count_d = write_count_q;
        cand_count_d  = cand_count_q;
        scan_ptr_d    = scan_ptr_q;
        sbox_we_d     = 1'b0;
        sbox_wdata_d  = sbox_wdata_q;
        filled_d      = filled_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = COLLECT;
                    used_d        = '0;
                    write_count_d = '0;
                    cand_count_d  = '0;
                    scan_ptr_d    = '0;
                    filled_d      = 1'b0;
                end
            end
            COLLECT: begin
                if (cand_valid) begin
                    cand_count_d = cand_count_q + CNT_W'(1);
                    if (!used_q[cand_data]) begin
                        used_d[cand_data] = 1'b1;
                        write_count_d     = write_count_q + 9'd1;
                        sbox_we_d         = 1'b1;
                        sbox_wdata_d      = cand_data;
                    end
                    // Completion outranks budget exhaustion on the same edge.
                    if (write_count_d == 9'd256) begin
                        state_d = DONE;
                    end else if (cand_count_d == CNT_W'(MAX_CANDIDATES)) begin
                        state_d  = FILL;
                        filled_d = 1'b1;
                    end
                end
            end
            FILL: begin
                // Every unused value lies at or above scan_ptr, so no wrap.
                scan_ptr_d = scan_ptr_q + 8'd1;
                if (!used_q[scan_ptr_q]) begin
                    used_d[scan_ptr_q] = 1'b1;
                    write_count_d      = write_count_q + 9'd1;
                    sbox_we_d          = 1'b1;
                    sbox_wdata_d       = scan_ptr_q;
                end
                if (write_count_d == 9'd256) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the bitmap is a plain flop vector, not a RAM macro, so
            // clearing it in reset is legal and keeps a fresh build clean.
            state_q       <= IDLE;
            used_q        <= '0;
            write_count_q <= '0;
            cand_count_q  <= '0;
            scan_ptr_q    <= '0;
            sbox_we_q     <= 1'b0;
            sbox_wdata_q  <= '0;
            filled_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            used_q        <= used_d;
            write_count_q <= write_count_d;
            cand_count_q  <= cand_count_d;
            scan_ptr_q    <= scan_ptr_d;
            sbox_we_q     <= sbox_we_d;
            sbox_wdata_q  <= sbox_wdata_d;
            filled_q      <= filled_d;
        end
    end

    assign cand_ready  = (state_q == COLLECT);
    assign busy        = (state_q == COLLECT) || (state_q == FILL);
    assign done        = (state_q == DONE);
    assign filled      = filled_q;
    assign sbox_we     = sbox_we_q;
    assign sbox_wdata  = sbox_wdata_q;
    assign write_count = write_count_q;
    assign cand_count  = cand_count_q;

endmodule

// File: tb/tb_sbox_build_ctrl.sv
// Testbench for sbox_build_ctrl: a set-based reference model predicts every
// S-box write (value and cycle); a negedge monitor pops and compares.
module tb_sbox_build_ctrl;

    localparam int MAXC  = 300;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             cand_valid;
    logic [7:0]       cand_data;
    logic             cand_ready;
    logic             sbox_we;
    logic [7:0]       sbox_wdata;
    logic             busy;
    logic             done;
    logic             filled;
    logic [8:0]       write_count;
    logic [CNT_W-1:0] cand_count;

    sbox_build_ctrl #(.MAX_CANDIDATES(MAXC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cand_valid(cand_valid), .cand_data(cand_data), .cand_ready(cand_ready),
        .sbox_we(sbox_we), .sbox_wdata(sbox_wdata),
        .busy(busy), .done(done), .filled(filled),
        .write_count(write_count), .cand_count(cand_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: a set of values already placed in the S-box.
    bit m_used[256];
    int m_uniq;
    int m_acc;
    bit m_collecting;
    bit m_filled;

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_used[i] = 1'b0;
        m_uniq = 0;
        m_acc = 0;
        m_collecting = 1'b1;
        m_filled = 1'b0;
    endtask

    // Monitor: every observed write must match the next expected one.
    always @(negedge clk) begin
        if (sbox_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got data %0h with nothing expected (cycle %0d)", sbox_wdata, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wdata", sbox_wdata, e.data);
                check("wcycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        cand_valid = 1'b0;
        cand_data = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("reset_outputs",
              {cand_ready, sbox_we, sbox_wdata, busy, done, filled, write_count, cand_count}, 64'd0);
    endtask

    task automatic start_build();
        start = 1'b1;
        cand_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
        check("start_counts", {write_count, cand_count, filled}, 64'd0);
        check("start_busy", {busy, done, cand_ready}, 64'b101);
    endtask

    // Present one candidate for one cycle and update the model as accepted.
    task automatic feed(input logic [7:0] d, input logic v);
        cand_valid = v;
        cand_data = d;
        if (!cand_ready) check("cand_ready_collect", cand_ready, 1'b1);
        @(posedge clk); #1;
        if (v) begin
            m_acc++;
            if (!m_used[d]) begin
                m_used[d] = 1'b1;
                m_uniq++;
                exp_q.push_back('{data: d, cyc: cyc});
            end
            if (m_uniq == 256) begin
                m_collecting = 1'b0;
            end else if (m_acc == MAXC) begin
                // Ascending fill: value v is scanned v edges after entering FILL.
                m_collecting = 1'b0;
                m_filled = 1'b1;
                for (int i = 0; i < 256; i++)
                    if (!m_used[i]) exp_q.push_back('{data: 8'(i), cyc: cyc + 1 + i});
            end
        end
        cand_valid = 1'b0;
    endtask

    task automatic finish_build();
        int waited;
        waited = 0;
        while (done !== 1'b1 && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        if (done !== 1'b1) check("done_timeout", done, 1'b1);
        check("end_done_busy_ready", {done, busy, cand_ready}, 64'b100);
        check("end_filled", filled, m_filled);
        check("end_write_count", write_count, 256);
        check("end_cand_count", cand_count, m_acc);
        @(posedge clk); #1;
        check("end_queue_drained", exp_q.size(), 0);
        check("done_holds", done, 1'b1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cand_valid = 1'b0; cand_data = 8'h00;
        model_clear();
        do_reset();

        // Ordered stream 0x00..0xFF.
        start_build();
        for (int i = 0; i < 256; i++) feed(8'(i), 1'b1);
        finish_build();

        // Duplicates, ignored start mid-build, then budget exhaustion.
        start_build();
        feed(8'h05, 1'b1);
        feed(8'h05, 1'b1);
        feed(8'h07, 1'b1);
        feed(8'h05, 1'b1);
        check("dup_write_count", write_count, 2);
        check("dup_cand_count", cand_count, 4);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_ignored_counts", {write_count, cand_count}, {9'd2, 16'd4});
        check("start_ignored_busy", busy, 1'b1);
        while (m_collecting) feed(8'hAA, 1'b1);
        finish_build();

        // Constant stream forces FILL after the budget.
        start_build();
        while (m_collecting) feed(8'hAA, 1'b1);
        check("fill_entered", {filled, busy, cand_ready}, 64'b110);
        finish_build();

        // Random data with 50% valid.
        start_build();
        while (m_collecting) feed(8'($urandom), 1'($urandom_range(0, 1)));
        finish_build();

        // Abort mid-collect after 100 unique writes, then a fresh build.
        start_build();
        while (m_uniq < 100) feed(8'($urandom), 1'b1);
        check("abort_write_count", write_count, 100);
        do_reset();
        @(posedge clk); #1;
        check("idle_after_reset", {busy, done, cand_ready}, 64'd0);
        start_build();
        while (m_collecting) feed(8'($urandom), 1'($urandom_range(0, 1)));
        finish_build();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
